// File: rtl/key_debounce.sv
// key_debounce: per-key pushbutton debouncer with press/release strobes.
// Each raw active-low key is double-flop synchronized, then qualified by an
// independent four-state FSM that only accepts a level after it has been
// stable for DEBOUNCE_CYCLES consecutive cycles.
// Optional sticky press capture flags are built only when the macro
// KEY_EDGE_CAPTURE_EN is defined; otherwise capture is tied low.

module key_debounce #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_raw_n,
    output logic [N_KEYS-1:0] keys_db_n,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] capture,
    input  logic [N_KEYS-1:0] capture_clr
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [N_KEYS-1:0] s1_q;
    logic [N_KEYS-1:0] s2_q;

    // Two-flop synchronizer; idles high so a reset looks like "not pressed".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= keys_raw_n;
            s2_q <= s1_q;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             db_q;
        logic             press_q;
        logic             release_q;

        // Debounce FSM with registered level and one-cycle strobes.
        // The counter only advances inside a WAIT state and stops at
        // CNT_LAST, where the level is accepted, so it never wraps.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q   <= RELEASED;
                cnt_q     <= '0;
                db_q      <= 1'b1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state_q)
                    RELEASED: begin
                        if (!s2_q[g]) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (s2_q[g]) begin
                            state_q <= RELEASED;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= PRESSED;
                            db_q    <= 1'b0;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (s2_q[g]) begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!s2_q[g]) begin
                            state_q <= PRESSED;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q   <= RELEASED;
                            db_q      <= 1'b1;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                        db_q    <= 1'b1;
                    end
                endcase
            end
        end

        assign keys_db_n[g]     = db_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;
    end

`ifdef KEY_EDGE_CAPTURE_EN
    logic [N_KEYS-1:0] capture_q;

    // Sticky press flags; a press strobe wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capture_q <= '0;
        end else begin
            capture_q <= press_pulse | (capture_q & ~capture_clr);
        end
    end

    assign capture = capture_q;
`else
    logic unused_capture_clr;

    assign capture            = '0;
    assign unused_capture_clr = ^capture_clr;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: self-checking bench for key_debounce with DEBOUNCE_CYCLES=4.
// Expected strobe/level events are queued per test and consumed at the edge
// they are due; all other edges must show no strobes and a held level.

module tb_key_debounce;

    localparam int D = 4;

`ifdef KEY_EDGE_CAPTURE_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    typedef struct {
        int         edge_n;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] db;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [2:0] keys_raw_n;
    logic [2:0] keys_db_n;
    logic [2:0] press_pulse;
    logic [2:0] release_pulse;
    logic [2:0] capture;
    logic [2:0] capture_clr;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    key_debounce #(
        .N_KEYS          (3),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .keys_raw_n    (keys_raw_n),
        .keys_db_n     (keys_db_n),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .capture       (capture),
        .capture_clr   (capture_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #1;
        n_tests++;
        if (keys_db_n !== 3'b111 || press_pulse !== 3'b000 || release_pulse !== 3'b000 || capture !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async: db=%b pr=%b rl=%b cap=%b, expected 111/000/000/000",
                     keys_db_n, press_pulse, release_pulse, capture);
        end
        for (int c = 0; c < 7; c++) begin
            if (c == 3) begin
                @(negedge clk);
                reset = 1'b0;
            end
            @(posedge clk); #1;
            n_tests++;
            if (keys_db_n !== 3'b111 || press_pulse !== 3'b000 || release_pulse !== 3'b000 || capture !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d: db=%b pr=%b rl=%b cap=%b, expected 111/000/000/000",
                         c, keys_db_n, press_pulse, release_pulse, capture);
            end
        end
    endtask

    task automatic test_press();
        exp_t       x;
        logic [2:0] db_e = 3'b111;
        logic [2:0] pr_e;
        logic [2:0] rl_e;
        sb.delete();
        sb.push_back('{D + 2, 3'b001, 3'b000, 3'b110});
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            keys_raw_n = 3'b110;
            @(posedge clk); #1;
            pr_e = 3'b000;
            rl_e = 3'b000;
            if (sb.size() != 0 && sb[0].edge_n == e) begin
                x    = sb.pop_front();
                pr_e = x.press;
                rl_e = x.rel;
                db_e = x.db;
            end
            n_tests++;
            if (keys_db_n !== db_e || press_pulse !== pr_e || release_pulse !== rl_e ||
                (!CAP_EN && capture !== 3'b000)) begin
                n_fail++;
                $display("FAIL press e=%0d: db=%b pr=%b rl=%b cap=%b, expected db=%b pr=%b rl=%b",
                         e, keys_db_n, press_pulse, release_pulse, capture, db_e, pr_e, rl_e);
            end
        end
    endtask

    task automatic test_release_simul();
        exp_t       x;
        logic [2:0] db_e = 3'b110;
        logic [2:0] pr_e;
        logic [2:0] rl_e;
        sb.delete();
        sb.push_back('{D + 2,  3'b100, 3'b000, 3'b010});
        sb.push_back('{D + 12, 3'b000, 3'b101, 3'b111});
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            keys_raw_n = (e < 10) ? 3'b010 : 3'b111;
            @(posedge clk); #1;
            pr_e = 3'b000;
            rl_e = 3'b000;
            if (sb.size() != 0 && sb[0].edge_n == e) begin
                x    = sb.pop_front();
                pr_e = x.press;
                rl_e = x.rel;
                db_e = x.db;
            end
            n_tests++;
            if (keys_db_n !== db_e || press_pulse !== pr_e || release_pulse !== rl_e ||
                (!CAP_EN && capture !== 3'b000)) begin
                n_fail++;
                $display("FAIL release_simul e=%0d: db=%b pr=%b rl=%b cap=%b, expected db=%b pr=%b rl=%b",
                         e, keys_db_n, press_pulse, release_pulse, capture, db_e, pr_e, rl_e);
            end
        end
    endtask

    task automatic test_bounce();
        for (int e = 0; e < 15; e++) begin
            @(negedge clk);
            keys_raw_n = (e <= 2 || (e >= 4 && e <= 6)) ? 3'b101 : 3'b111;
            @(posedge clk); #1;
            n_tests++;
            if (keys_db_n !== 3'b111 || press_pulse !== 3'b000 || release_pulse !== 3'b000 ||
                (!CAP_EN && capture !== 3'b000)) begin
                n_fail++;
                $display("FAIL bounce e=%0d: db=%b pr=%b rl=%b cap=%b, expected db=111 pr=000 rl=000",
                         e, keys_db_n, press_pulse, release_pulse, capture);
            end
        end
    endtask

    // Four stable samples then one bounce: qualification must restart, so the
    // press lands D+2 edges after the key goes low again at edge 5.
    task automatic test_bounce_restart();
        exp_t       x;
        logic [2:0] db_e = 3'b111;
        logic [2:0] pr_e;
        logic [2:0] rl_e;
        sb.delete();
        sb.push_back('{5 + D + 2,  3'b001, 3'b000, 3'b110});
        sb.push_back('{14 + D + 2, 3'b000, 3'b001, 3'b111});
        for (int e = 0; e < 24; e++) begin
            @(negedge clk);
            keys_raw_n = (e == 4 || e >= 14) ? 3'b111 : 3'b110;
            @(posedge clk); #1;
            pr_e = 3'b000;
            rl_e = 3'b000;
            if (sb.size() != 0 && sb[0].edge_n == e) begin
                x    = sb.pop_front();
                pr_e = x.press;
                rl_e = x.rel;
                db_e = x.db;
            end
            n_tests++;
            if (keys_db_n !== db_e || press_pulse !== pr_e || release_pulse !== rl_e ||
                (!CAP_EN && capture !== 3'b000)) begin
                n_fail++;
                $display("FAIL bounce_restart e=%0d: db=%b pr=%b rl=%b cap=%b, expected db=%b pr=%b rl=%b",
                         e, keys_db_n, press_pulse, release_pulse, capture, db_e, pr_e, rl_e);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t       x;
        logic [2:0] db_e = 3'b111;
        logic [2:0] pr_e;
        logic [2:0] rl_e;
        sb.delete();
        sb.push_back('{D + 2,  3'b111, 3'b000, 3'b000});
        sb.push_back('{D + 10, 3'b000, 3'b111, 3'b111});
        sb.push_back('{D + 18, 3'b111, 3'b000, 3'b000});
        for (int e = 0; e < 34; e++) begin
            @(negedge clk);
            keys_raw_n = (e >= 8 && e < 16) ? 3'b111 : 3'b000;
            @(posedge clk); #1;
            pr_e = 3'b000;
            rl_e = 3'b000;
            if (sb.size() != 0 && sb[0].edge_n == e) begin
                x    = sb.pop_front();
                pr_e = x.press;
                rl_e = x.rel;
                db_e = x.db;
            end
            n_tests++;
            if (keys_db_n !== db_e || press_pulse !== pr_e || release_pulse !== rl_e ||
                (!CAP_EN && capture !== 3'b000)) begin
                n_fail++;
                $display("FAIL back_to_back e=%0d: db=%b pr=%b rl=%b cap=%b, expected db=%b pr=%b rl=%b",
                         e, keys_db_n, press_pulse, release_pulse, capture, db_e, pr_e, rl_e);
            end
        end
    endtask

    task automatic test_reset_midqual();
        exp_t       x;
        logic [2:0] db_e = 3'b111;
        logic [2:0] pr_e;
        logic [2:0] rl_e;
        @(negedge clk);
        keys_raw_n = 3'b111;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // Key 0 low from edge 0: counter reaches 2 at edge 4.
        for (int e = 0; e < 5; e++) begin
            @(negedge clk);
            keys_raw_n = 3'b110;
            @(posedge clk); #1;
            n_tests++;
            if (keys_db_n !== 3'b111 || press_pulse !== 3'b000 || release_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL midqual_pre e=%0d: db=%b pr=%b rl=%b, expected db=111 pr=000 rl=000",
                         e, keys_db_n, press_pulse, release_pulse);
            end
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(posedge clk);
            #1;
            n_tests++;
            if (keys_db_n !== 3'b111 || press_pulse !== 3'b000 || release_pulse !== 3'b000 || capture !== 3'b000) begin
                n_fail++;
                $display("FAIL midqual_in_reset c=%0d: db=%b pr=%b rl=%b cap=%b, expected 111/000/000/000",
                         c, keys_db_n, press_pulse, release_pulse, capture);
            end
        end
        sb.delete();
        sb.push_back('{D + 2, 3'b001, 3'b000, 3'b110});
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            keys_raw_n = 3'b110;
            if (e == 0) reset = 1'b0;
            @(posedge clk); #1;
            pr_e = 3'b000;
            rl_e = 3'b000;
            if (sb.size() != 0 && sb[0].edge_n == e) begin
                x    = sb.pop_front();
                pr_e = x.press;
                rl_e = x.rel;
                db_e = x.db;
            end
            n_tests++;
            if (keys_db_n !== db_e || press_pulse !== pr_e || release_pulse !== rl_e) begin
                n_fail++;
                $display("FAIL midqual_post e=%0d: db=%b pr=%b rl=%b, expected db=%b pr=%b rl=%b",
                         e, keys_db_n, press_pulse, release_pulse, db_e, pr_e, rl_e);
            end
        end
    endtask

`ifdef KEY_EDGE_CAPTURE_EN
    // Clear at edge 23 coincides with the second press strobe (set wins);
    // clear alone at edge 25 drops the flag.
    task automatic test_capture();
        exp_t       x;
        logic [2:0] db_e = 3'b111;
        logic [2:0] pr_e;
        logic [2:0] rl_e;
        logic [2:0] cap_e;
        @(negedge clk);
        keys_raw_n = 3'b111;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        sb.push_back('{D + 2,  3'b100, 3'b000, 3'b011});
        sb.push_back('{D + 10, 3'b000, 3'b100, 3'b111});
        sb.push_back('{D + 18, 3'b100, 3'b000, 3'b011});
        for (int e = 0; e < 28; e++) begin
            @(negedge clk);
            keys_raw_n  = (e >= 8 && e < 16) ? 3'b111 : 3'b011;
            capture_clr = (e == 23 || e == 25) ? 3'b100 : 3'b000;
            @(posedge clk); #1;
            pr_e  = 3'b000;
            rl_e  = 3'b000;
            cap_e = (e >= 7 && e < 25) ? 3'b100 : 3'b000;
            if (sb.size() != 0 && sb[0].edge_n == e) begin
                x    = sb.pop_front();
                pr_e = x.press;
                rl_e = x.rel;
                db_e = x.db;
            end
            n_tests++;
            if (keys_db_n !== db_e || press_pulse !== pr_e || release_pulse !== rl_e || capture !== cap_e) begin
                n_fail++;
                $display("FAIL capture e=%0d: db=%b pr=%b rl=%b cap=%b, expected db=%b pr=%b rl=%b cap=%b",
                         e, keys_db_n, press_pulse, release_pulse, capture, db_e, pr_e, rl_e, cap_e);
            end
        end
        capture_clr = 3'b000;
    endtask
`endif

    initial begin
        reset       = 1'b1;
        keys_raw_n  = 3'b111;
        capture_clr = 3'b000;
        test_reset();
        test_press();
        test_release_simul();
        test_bounce();
        test_bounce_restart();
        test_back_to_back();
        test_reset_midqual();
`ifdef KEY_EDGE_CAPTURE_EN
        test_capture();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
